// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

  localparam int D_DEFAULT  = 12;
  localparam int CW_DEFAULT = 16;
  localparam int PC_RESET   = 0;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter stage fed by the branch-target table.
// It owns the Start/Done run protocol and counts RUN cycles.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int D  = D_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          start,
  input  logic [D-1:0]  start_addr,
  input  logic          stall,
  input  logic          halt,
  input  logic          abs_jump,
  input  logic          branch_en,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val);
    return (val == {CW{1'b1}}) ? val : val + 1'b1;
  endfunction

  pc_state_t      r_state;
  pc_state_t      w_state_nxt;
  logic [D-1:0]   r_pc;
  logic [D-1:0]   w_pc_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic           r_running;
  logic           r_done;

  logic signed [D-1:0] w_offset;
  logic signed [D-1:0] w_pc_signed;
  logic        [D-1:0] w_branch_pc;

  // Relative branches add a two's-complement offset and wrap mod 2^D.
  assign w_offset    = target;
  assign w_pc_signed = r_pc;
  assign w_branch_pc = w_pc_signed + w_offset;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = start_addr;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        w_cnt_nxt = sat_inc(r_cnt);
        if (stall) begin
          w_pc_nxt = r_pc;
        end else if (halt) begin
          w_state_nxt = DONE;
        end else if (abs_jump) begin
          w_pc_nxt = target;
        end else if (branch_en) begin
          w_pc_nxt = w_branch_pc;
        end else begin
          w_pc_nxt = r_pc + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so outputs stay flop-driven.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc      <= D'(PC_RESET);
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_running <= (w_state_nxt == RUN);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  assign prog_ctr  = r_pc;
  assign running   = r_running;
  assign done      = r_done;
  assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  localparam int D  = 12;
  localparam int CW = 16;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          start;
  logic [D-1:0]  start_addr;
  logic          stall;
  logic          halt;
  logic          abs_jump;
  logic          branch_en;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic [CW-1:0] cycle_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(.D(D), .CW(CW)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .start_addr(start_addr),
    .stall     (stall),
    .halt      (halt),
    .abs_jump  (abs_jump),
    .branch_en (branch_en),
    .target    (target),
    .prog_ctr  (prog_ctr),
    .running   (running),
    .done      (done),
    .cycle_cnt (cycle_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    start = 0; stall = 0; halt = 0; abs_jump = 0; branch_en = 0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic jump_abs(input logic [D-1:0] addr);
    clear_ctl(); abs_jump = 1; target = addr;
    step();
    clear_ctl();
  endtask

  task automatic branch(input logic [D-1:0] off);
    clear_ctl(); branch_en = 1; target = off;
    step();
    clear_ctl();
  endtask

  initial begin
    clear_ctl();
    start_addr = '0;
    target     = '0;
    Reset_n    = 0;
    #12;
    check("rst_pc", prog_ctr, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cycle_cnt, 0);
    Reset_n = 1;

    // IDLE ignores control inputs other than start
    abs_jump = 1; target = 12'd77; branch_en = 1;
    step();
    clear_ctl();
    check("idle_hold_pc", prog_ctr, 0);
    check("idle_running", running, 0);

    start = 1; start_addr = 12'd100;
    step();
    clear_ctl();
    check("start_pc", prog_ctr, 100);
    check("start_running", running, 1);
    check("start_cnt", cycle_cnt, 0);
    step();
    check("seq_pc1", prog_ctr, 101);
    start = 1; start_addr = 12'd500;
    step();
    clear_ctl();
    check("start_in_run_ignored", prog_ctr, 102);
    step();
    check("seq_pc3", prog_ctr, 103);
    check("seq_cnt3", cycle_cnt, 3);

    jump_abs(12'd100);
    check("abs_100", prog_ctr, 100);
    branch(12'hFEF);
    check("branch_m17", prog_ctr, 83);
    branch(12'd15);
    check("branch_p15", prog_ctr, 98);

    jump_abs(12'd5);
    branch(12'hFE4);
    check("branch_wrap_down", prog_ctr, 4073);
    jump_abs(12'd4095);
    step();
    check("inc_wrap_up", prog_ctr, 0);

    jump_abs(12'd40);
    stall = 1; halt = 1;
    step();
    check("stall_halt_pc", prog_ctr, 40);
    check("stall_halt_running", running, 1);
    check("stall_halt_done", done, 0);
    stall = 0;
    step();
    clear_ctl();
    check("halt_done", done, 1);
    check("halt_running", running, 0);
    check("halt_pc", prog_ctr, 40);
    check("halt_cnt", cycle_cnt, 13);
    abs_jump = 1; target = 12'd9;
    step();
    clear_ctl();
    check("done_hold_pc", prog_ctr, 40);
    check("done_hold_cnt", cycle_cnt, 13);
    check("done_hold_done", done, 1);

    start = 1; start_addr = 12'd200;
    step();
    clear_ctl();
    check("restart_pc", prog_ctr, 200);
    check("restart_done", done, 0);
    check("restart_running", running, 1);
    check("restart_cnt", cycle_cnt, 0);

    abs_jump = 1; branch_en = 1; target = 12'd300;
    step();
    clear_ctl();
    check("abs_over_branch", prog_ctr, 300);
    branch(12'd0);
    check("branch_zero_hold", prog_ctr, 300);
    check("branch_zero_cnt", cycle_cnt, 2);

    jump_abs(12'd57);
    check("pre_reset_pc", prog_ctr, 57);
    #2;
    Reset_n = 0;
    #1;
    check("async_rst_pc", prog_ctr, 0);
    check("async_rst_running", running, 0);
    check("async_rst_done", done, 0);
    check("async_rst_cnt", cycle_cnt, 0);
    step();
    Reset_n = 1;

    // Self-loop long enough to saturate the run-cycle counter
    start = 1; start_addr = 12'd10;
    step();
    clear_ctl();
    branch_en = 1; target = 12'd0;
    for (int i = 0; i < 65540; i++) step();
    clear_ctl();
    check("sat_cnt", cycle_cnt, 65535);
    check("sat_pc", prog_ctr, 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the branch-target lookup table.
- Consumes the table's D-bit signed relative offset (or absolute target) and advances the instruction-fetch address each cycle.
- Owns the Start/Done run protocol for a program and a run-cycle counter.
- Output prog_ctr drives instruction ROM address; done goes to the testbench/top level.

Parameters:
- D, 12, width of program counter and of target input.
- CW, 16, width of run-cycle counter.

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin program run; sampled in IDLE/DONE only.
- start_addr  input  D  first instruction address of selected program.
- stall  input  1  hold PC this cycle (RUN only).
- halt  input  1  current instruction is end-of-program.
- abs_jump  input  1  load target as absolute address.
- branch_en  input  1  taken relative branch (condition already resolved upstream).
- target  input  D  from lookup table; signed offset for branch_en, unsigned address for abs_jump.
- prog_ctr  output  D  current fetch address.
- running  output  1  high in RUN.
- done  output  1  high in DONE.
- cycle_cnt  output  CW  RUN cycles since last start.

Behaviour:
- Reset (Reset_n=0, asynchronous): state=IDLE, prog_ctr=0, done=0, running=0, cycle_cnt=0. Outputs remain at reset values until the first start after deassertion.
- States: IDLE, RUN, DONE; all outputs registered; no combinational path from any input to any output.
- IDLE:
  - prog_ctr holds.
  - start=1 -> next edge: prog_ctr<=start_addr, cycle_cnt<=0, state RUN.
  - All other inputs ignored.
- RUN, evaluated each edge, first match wins:
  - stall=1 -> prog_ctr holds (halt/branch ignored).
  - halt=1 -> prog_ctr holds, state DONE.
  - abs_jump=1 -> prog_ctr<=target.
  - branch_en=1 -> prog_ctr <= prog_ctr + target, target treated as two's complement, sum truncated to D bits (wraps mod 2^D both directions). target=0 leaves PC unchanged, which yields a deliberate self-loop.
  - Otherwise prog_ctr<=prog_ctr+1, wrapping 2^D-1 -> 0.
- cycle_cnt in RUN:
  - Increments every RUN cycle, including stalled cycles and the halt cycle.
  - Saturates at 2^CW-1.
  - Holds in IDLE/DONE.
- start asserted while in RUN is ignored.
- DONE:
  - done=1, running=0; prog_ctr and cycle_cnt hold.
  - start=1 -> next edge: prog_ctr<=start_addr, cycle_cnt<=0, done<=0, state RUN.
- running=1 exactly while state=RUN.
- Reset asserted mid-RUN: immediate return to reset values, no completion of the pending update.

Decomposition:
- Shared package pc_pkg holds:
  - state enum typedef pc_state_t {IDLE, RUN, DONE}
  - default D and CW constants
  - PC_RESET=0
- No sub-module is required. Next-PC selection is a single combinational block inside pc_sequencer; the lookup table remains a separate instance at top level.

Test Plan:
- Reset then start=1, start_addr=100, no control for 3 cycles -> prog_ctr 100,101,102,103; running=1; cycle_cnt=3.
- prog_ctr=100, branch_en=1, target=-17 (12'hFEF) -> prog_ctr=83; then target=15 -> prog_ctr=98.
- prog_ctr=5, branch_en=1, target=-28 -> prog_ctr=4073 (wrap); prog_ctr=4095 with no control -> 0.
- stall=1 and halt=1 together at prog_ctr=40 -> prog_ctr stays 40, state RUN. Drop stall with halt=1 -> next edge done=1, running=0, prog_ctr=40. Then start=1, start_addr=200 -> prog_ctr=200, done=0.
- abs_jump=1 and branch_en=1 with target=12'd300 -> prog_ctr=300 (absolute wins). branch_en=1, target=0 -> prog_ctr holds.
- Reset_n pulled low mid-RUN between edges (prog_ctr=57) -> prog_ctr=0, running=0, done=0 immediately, without a clock edge.
